// File: rtl/obi_pkg.sv
// Shared OBI bus types, grant FSM states and the out-of-range read pattern.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } gnt_state_e;

    localparam logic [31:0] OBI_ERR_RDATA = 32'hBADC_AB1E;

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI request/response bundle; master drives req, slave drives resp.
interface obi_mem_responder_if;
    import obi_pkg::*;

    obi_req_t  req;
    obi_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/obi_mem_bank.sv
// Single-port word memory with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after en_i; no backpressure, one op per cycle.
module obi_mem_bank #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned AW        = 10
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [NUM_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory slave: optional grant wait states, responses RESP_LATENCY cycles after grant.
// Backpressure only through gnt; with WAIT_CYCLES=0 it accepts a transfer every cycle.
module obi_mem_responder
    import obi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h2001_0000,
    parameter int unsigned NUM_WORDS    = 1024,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  obi_req_i,
    output obi_resp_t obi_resp_o,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned AW        = $clog2(NUM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(NUM_WORDS) * 33'd4;
    localparam logic [2:0]  WAIT_LAST = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    gnt_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gnt_raw;
    logic        accept;
    logic [31:0] offset;
    logic        in_range;
    logic [31:0] bank_rdata;
    logic [RESP_LATENCY:1] vld_q;
    logic        s1_rd_q, s1_err_q;
    logic [31:0] s1_dat, rsp_dat;
    logic [15:0] err_cnt_q;
    logic        rvalid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (WAIT_CYCLES == 0) begin
                    gnt_raw = obi_req_i.req;
                end else if (obi_req_i.req) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (!obi_req_i.req) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d >= WAIT_LAST) state_d = ST_READY;
                end
            end
            ST_READY: begin
                // Either granted now or req was withdrawn; both end the wait.
                gnt_raw = obi_req_i.req;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept   = obi_req_i.req & gnt_raw & ~rst_i;
    assign offset   = obi_req_i.addr - BASE_ADDR;
    assign in_range = ({1'b0, offset} < MEM_BYTES);

    obi_mem_bank #(
        .NUM_WORDS (NUM_WORDS),
        .AW        (AW)
    ) u_bank (
        .clk_i   (clk_i),
        .en_i    (accept & in_range),
        .we_i    (obi_req_i.we),
        .be_i    (obi_req_i.be),
        .addr_i  (offset[AW+1:2]),
        .wdata_i (obi_req_i.wdata),
        .rdata_o (bank_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            vld_q[1] <= accept;
            for (int k = 2; k <= RESP_LATENCY; k++) vld_q[k] <= vld_q[k-1];
            if (accept && !in_range && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        s1_rd_q  <= ~obi_req_i.we;
        s1_err_q <= ~in_range;
    end

    // The bank register is stage 1, so read data is resolved one cycle after grant.
    always_comb begin
        s1_dat = '0;
        if (vld_q[1] && s1_rd_q) s1_dat = s1_err_q ? OBI_ERR_RDATA : bank_rdata;
    end

    generate
        if (RESP_LATENCY == 1) begin : g_lat1
            assign rsp_dat = s1_dat;
        end else begin : g_latn
            logic [RESP_LATENCY-1:1][31:0] dat_q;
            always_ff @(posedge clk_i) begin
                dat_q[1] <= s1_dat;
                for (int k = 2; k < RESP_LATENCY; k++) dat_q[k] <= dat_q[k-1];
            end
            assign rsp_dat = dat_q[RESP_LATENCY-1];
        end
    endgenerate

    assign rvalid = vld_q[RESP_LATENCY] & ~rst_i;

    always_comb begin
        obi_resp_o        = '0;
        obi_resp_o.gnt    = gnt_raw & ~rst_i;
        obi_resp_o.rvalid = rvalid;
        obi_resp_o.rdata  = rvalid ? rsp_dat : '0;
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder across three wait/latency configurations.
module tb_obi_mem_responder;
    import obi_pkg::*;

    logic clk;
    logic rst;
    logic [15:0] err0, err3, errl;
    obi_req_t req0, req3, reql;
    int n_chk = 0;
    int n_err = 0;
    int ncyc;
    logic [31:0] pv [4] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 32'hC001_D00D};

    obi_mem_responder_if bus0 ();
    obi_mem_responder_if bus3 ();
    obi_mem_responder_if busl ();

    assign bus0.req = req0;
    assign bus3.req = req3;
    assign busl.req = reql;

    obi_mem_responder #(.WAIT_CYCLES(0), .RESP_LATENCY(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .obi_req_i(bus0.req), .obi_resp_o(bus0.resp), .err_cnt_o(err0));
    obi_mem_responder #(.WAIT_CYCLES(3), .RESP_LATENCY(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .obi_req_i(bus3.req), .obi_resp_o(bus3.resp), .err_cnt_o(err3));
    obi_mem_responder #(.WAIT_CYCLES(0), .RESP_LATENCY(3)) u_dutl (
        .clk_i(clk), .rst_i(rst), .obi_req_i(busl.req), .obi_resp_o(busl.resp), .err_cnt_o(errl));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obi_req_t mk(input logic we, input logic [3:0] be,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        mk       = '0;
        mk.req   = 1'b1;
        mk.we    = we;
        mk.be    = be;
        mk.addr  = addr;
        mk.wdata = wdata;
    endfunction

    task automatic xfer0(input string tag, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        req0 = mk(we, be, addr, wdata);
        #1;
        chk({tag, "_gnt"}, 32'(bus0.resp.gnt), 32'd1);
        step();
        req0 = '0;
        chk({tag, "_vld"}, 32'(bus0.resp.rvalid), 32'd1);
        chk({tag, "_dat"}, bus0.resp.rdata, exp);
    endtask

    task automatic wait_gnt3(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 10 && cyc == 0; k++) begin
            #1;
            if (bus3.resp.gnt) cyc = k;
            else step();
        end
    endtask

    initial begin
        rst  = 1'b1;
        req0 = mk(1'b0, 4'hF, 32'h2001_0010, '0);
        req3 = '0;
        reql = '0;
        step();
        step();
        chk("rst_gnt", 32'(bus0.resp.gnt), 32'd0);
        chk("rst_vld", 32'(bus0.resp.rvalid), 32'd0);
        chk("rst_dat", bus0.resp.rdata, 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        rst  = 1'b0;
        req0 = '0;

        // Zero wait states, latency 1; write then read-after-write on the next cycle.
        xfer0("wr_beef", 1'b1, 4'hF, 32'h2001_0010, 32'hDEAD_BEEF, 32'd0);
        xfer0("rd_beef", 1'b0, 4'hF, 32'h2001_0010, 32'd0, 32'hDEAD_BEEF);
        step();
        chk("idle_vld", 32'(bus0.resp.rvalid), 32'd0);
        chk("idle_dat", bus0.resp.rdata, 32'd0);

        xfer0("wr_ones", 1'b1, 4'hF, 32'h2001_0020, 32'h1111_1111, 32'd0);
        xfer0("wr_byte2", 1'b1, 4'b0100, 32'h2001_0020, 32'h00AA_0000, 32'd0);
        xfer0("rd_merge", 1'b0, 4'hF, 32'h2001_0020, 32'd0, 32'h11AA_1111);

        req0 = '{req: 1'b0, we: 1'b1, be: 4'hF, addr: 32'h2001_0010, wdata: 32'h0BAD_0BAD};
        #1;
        chk("noreq_gnt", 32'(bus0.resp.gnt), 32'd0);
        step();
        chk("noreq_vld", 32'(bus0.resp.rvalid), 32'd0);
        xfer0("rd_unalgn", 1'b0, 4'hF, 32'h2001_0013, 32'd0, 32'hDEAD_BEEF);

        xfer0("wr_w0", 1'b1, 4'hF, 32'h2001_0000, 32'h55AA_55AA, 32'd0);
        xfer0("rd_oor", 1'b0, 4'hF, 32'h0000_0000, 32'd0, 32'hBADC_AB1E);
        chk("err_one", 32'(err0), 32'd1);
        xfer0("wr_oor", 1'b1, 4'hF, 32'h2001_1000, 32'h1234_5678, 32'd0);
        chk("err_two", 32'(err0), 32'd2);
        xfer0("rd_w0", 1'b0, 4'hF, 32'h2001_0000, 32'd0, 32'h55AA_55AA);

        // Three wait states: grant lands in the 4th cycle of a held request.
        req3 = mk(1'b1, 4'hF, 32'h2001_0040, 32'hA5A5_5A5A);
        wait_gnt3(ncyc);
        chk("w3_wr_cyc", 32'(ncyc), 32'd4);
        step();
        req3 = '0;
        chk("w3_wr_vld", 32'(bus3.resp.rvalid), 32'd1);
        req3 = mk(1'b0, 4'hF, 32'h2001_0040, 32'd0);
        wait_gnt3(ncyc);
        chk("w3_rd_cyc", 32'(ncyc), 32'd4);
        step();
        req3 = '0;
        chk("w3_rd_vld", 32'(bus3.resp.rvalid), 32'd1);
        chk("w3_rd_dat", bus3.resp.rdata, 32'hA5A5_5A5A);

        req3 = mk(1'b0, 4'hF, 32'h2001_0040, 32'd0);
        #1;
        chk("ab_gnt1", 32'(bus3.resp.gnt), 32'd0);
        step();
        #1;
        chk("ab_gnt2", 32'(bus3.resp.gnt), 32'd0);
        step();
        req3 = '0;
        #1;
        chk("ab_gnt3", 32'(bus3.resp.gnt), 32'd0);
        step();
        chk("ab_state", 32'(u_dut3.state_q), 32'(ST_IDLE));
        chk("ab_vld", 32'(bus3.resp.rvalid), 32'd0);

        // Latency 3: preload four words, then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            reql = mk(1'b1, 4'hF, 32'h2001_0100 + 32'(4 * i), pv[i]);
            step();
        end
        reql = '0;
        repeat (4) step();
        for (int c = 0; c < 9; c++) begin
            if (c < 4) reql = mk(1'b0, 4'hF, 32'h2001_0100 + 32'(4 * c), 32'd0);
            else reql = '0;
            #1;
            chk($sformatf("l3_gnt%0d", c), 32'(busl.resp.gnt), 32'(c < 4));
            chk($sformatf("l3_vld%0d", c), 32'(busl.resp.rvalid), 32'(c >= 3 && c < 7));
            chk($sformatf("l3_dat%0d", c), busl.resp.rdata, (c >= 3 && c < 7) ? pv[c-3] : 32'd0);
            step();
        end

        reql = mk(1'b0, 4'hF, 32'h0000_0000, 32'd0);
        step();
        reql = '0;
        repeat (3) step();
        chk("l3_err", 32'(errl), 32'd1);

        // Reset pulse while two responses are in flight.
        for (int c = 0; c < 7; c++) begin
            if (c < 2) reql = mk(1'b0, 4'hF, 32'h2001_0100 + 32'(4 * c), 32'd0);
            else reql = '0;
            rst = (c == 2);
            #1;
            chk($sformatf("rs_vld%0d", c), 32'(busl.resp.rvalid), 32'd0);
            step();
        end
        chk("rs_errl", 32'(errl), 32'd0);
        chk("rs_err0", 32'(err0), 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (c == 0) reql = mk(1'b0, 4'hF, 32'h2001_0104, 32'd0);
            else reql = '0;
            #1;
            if (c == 3) begin
                chk("rs_keep_vld", 32'(busl.resp.rvalid), 32'd1);
                chk("rs_keep_dat", busl.resp.rdata, pv[1]);
            end
            step();
        end
        xfer0("rs_keep0", 1'b0, 4'hF, 32'h2001_0010, 32'd0, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2001_0000, byte address of word 0.
REQ-002 SHALL have parameter NUM_WORDS, default 1024, memory depth in 32-bit words (power of two, >=4).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, range 0..7, idle cycles between req sampled and gnt.
REQ-004 SHALL have parameter RESP_LATENCY, default 1, range 1..4, cycles from grant to rvalid.
REQ-005 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port obi_req_i  input  obi_req_t  OBI request: req, we, be[3:0], addr[31:0], wdata[31:0].
REQ-008 SHALL have port obi_resp_o  output  obi_resp_t  OBI response: gnt, rvalid, rdata[31:0].
REQ-009 SHALL have port err_cnt_o  output  16  saturating count of out-of-range accesses.

Function
REQ-010 SHALL implement a grant FSM with states IDLE, WAIT, READY.
REQ-011 SHALL, with WAIT_CYCLES=0, stay in IDLE and drive gnt = req combinationally.
REQ-012 SHALL, with WAIT_CYCLES>0, leave IDLE for WAIT when req=1, clearing the wait counter.
REQ-013 SHALL, in WAIT, increment the wait counter each cycle and move to READY when the counter reaches WAIT_CYCLES-1.
REQ-014 SHALL, in READY, drive gnt = req and return to IDLE on the grant cycle.
REQ-015 SHALL return from WAIT or READY to IDLE, with no grant, if req drops before gnt.
REQ-016 SHALL treat a transfer as accepted only in a cycle where req=1 and gnt=1.
REQ-017 SHALL compute offset = addr - BASE_ADDR (32-bit, wrapping); access is in range iff offset < NUM_WORDS*4.
REQ-018 SHALL index the memory by offset[log2(NUM_WORDS)+1:2] and ignore addr[1:0].
REQ-019 SHALL, on an accepted in-range write, update only the bytes whose be bit is 1, visible to any later accepted read.
REQ-020 SHALL, on an accepted read, capture the addressed word in the grant cycle.
REQ-021 SHALL return rdata = 32'hBADC_AB1E for out-of-range reads, ignore out-of-range writes, and increment err_cnt_o (saturating at 16'hFFFF).
REQ-022 SHALL assert rvalid exactly RESP_LATENCY cycles after each accepted transfer, for exactly one cycle, through a RESP_LATENCY-stage {valid, rdata} shift pipeline.
REQ-023 SHALL drive rdata = 0 with the write response and for all non-rvalid cycles.
REQ-024 SHALL sustain one accepted transfer per cycle when WAIT_CYCLES=0 (back-to-back grants), with responses in order.
REQ-025 SHALL, for a read granted the cycle after a write to the same word, return the newly written data.
REQ-026 SHALL ignore we, be, addr and wdata when req=0.

Reset
REQ-027 SHALL, while rst_i=1 at a clock edge, set the FSM to IDLE, clear the wait counter, clear all pipeline valid bits, and clear err_cnt_o.
REQ-028 SHALL hold gnt=0, rvalid=0 and rdata=0 during reset, and SHALL drop in-flight responses when reset is asserted mid-transfer.
REQ-029 SHALL NOT reset memory contents.

Structure
REQ-030 SHALL take obi_req_t and obi_resp_t from obi_pkg.
REQ-031 SHALL place the constant OBI_ERR_RDATA = 32'hBADC_AB1E in obi_pkg.
REQ-032 SHALL implement storage as one sub-module obi_mem_bank: one synchronous port, per-byte write enable, read data registered.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=0, RESP_LATENCY=1; write 32'hDEAD_BEEF to 32'h2001_0010 with be=4'hF, then read it -> gnt in the same cycle as req; rdata=32'hDEAD_BEEF with rvalid one cycle after the read grant.
REQ-034 SHALL cover: be=4'b0100 write of 32'h00AA_0000 over 32'h1111_1111 -> read returns 32'h11AA_1111.
REQ-035 SHALL cover: WAIT_CYCLES=3, req held -> gnt in the 4th cycle of req; req dropped after 2 cycles -> no gnt and FSM back in IDLE.
REQ-036 SHALL cover: read at 32'h0000_0000 -> rdata=32'hBADC_AB1E and err_cnt_o=1; write at BASE_ADDR+NUM_WORDS*4 -> memory unchanged and err_cnt_o=2.
REQ-037 SHALL cover: RESP_LATENCY=3, reads of 4 distinct preloaded words on consecutive cycles -> 4 consecutive rvalid cycles starting 3 cycles after the first grant, data in order.
REQ-038 SHALL cover: rst_i asserted for 1 cycle with 2 responses in flight -> no rvalid afterwards and err_cnt_o=0; memory contents preserved.
